alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 35 +++
 rtl/alu_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request, response and ALU-side signals of the ALU sequencer, grouped so the
// sequencer (slave) and its environment (master: requester plus ALU) share one bundle.
interface alu_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_cmd;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_bcond;
  logic                  rsp_err;

  logic [6:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_in_1;
  logic [DATA_WIDTH-1:0] alu_in_2;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_bcond;

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, rsp_ready, alu_result, alu_bcond,
    output req_ready, rsp_valid, rsp_result, rsp_bcond, rsp_err,
           alu_op, alu_in_1, alu_in_2
  );

  modport master (
    output req_valid, req_cmd, req_a, req_b, rsp_ready, alu_result, alu_bcond,
    input  req_ready, rsp_valid, rsp_result, rsp_bcond, rsp_err,
           alu_op, alu_in_1, alu_in_2
  );
endinterface

// File: rtl/alu_sequencer.sv
// Command sequencer in front of an external combinational ALU; multi-bit shifts
// are built by iterating the ALU's single-bit shift operations.
module alu_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            reset_n,
  alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

  localparam logic [6:0] OP_ZERO = 7'h0F;
  localparam logic [6:0] OP_ID   = 7'h02;

  state_t                state_q, state_d;
  logic [3:0]            cmd_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [4:0]            cnt_q;
  logic                  bcond_q, err_q;

  logic [6:0]            exec_op, shift_op, alu_op;
  logic [DATA_WIDTH-1:0] alu_in_1, alu_in_2;
  logic                  cmd_branch, cmd_illegal, req_shift;

  assign cmd_branch  = (cmd_q[3:2] == 2'b10);
  assign cmd_illegal = (cmd_q >= 4'd13);
  assign req_shift   = (bus.req_cmd inside {4'd5, 4'd6, 4'd7}) && (bus.req_b[4:0] != 5'd0);

  // A shift by zero reaches EXEC and degenerates to the identity operation.
  always_comb begin
    exec_op = OP_ZERO;
    case (cmd_q)
      4'd0:                exec_op = 7'h00;
      4'd1:                exec_op = 7'h01;
      4'd2:                exec_op = 7'h04;
      4'd3:                exec_op = 7'h05;
      4'd4:                exec_op = 7'h08;
      4'd5, 4'd6, 4'd7:    exec_op = OP_ID;
      4'd8:                exec_op = 7'h41;
      4'd9:                exec_op = 7'h51;
      4'd10:               exec_op = 7'h61;
      4'd11:               exec_op = 7'h71;
      4'd12:               exec_op = 7'h0E;
      default:             exec_op = OP_ZERO;
    endcase
  end

  always_comb begin
    shift_op = 7'h0A;
    case (cmd_q)
      4'd6:    shift_op = 7'h0B;
      4'd7:    shift_op = 7'h0D;
      default: shift_op = 7'h0A;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    alu_op   = OP_ZERO;
    alu_in_1 = '0;
    alu_in_2 = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) state_d = req_shift ? SHIFT : EXEC;
      end
      EXEC: begin
        alu_op   = exec_op;
        alu_in_1 = a_q;
        alu_in_2 = b_q;
        state_d  = RESP;
      end
      SHIFT: begin
        alu_op   = shift_op;
        alu_in_1 = acc_q;
        if (cnt_q == 5'd1) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      bcond_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            cmd_q <= bus.req_cmd;
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            acc_q <= bus.req_a;
            cnt_q <= bus.req_b[4:0];
          end
        end
        EXEC: begin
          result_q <= cmd_illegal ? '0 : bus.alu_result;
          bcond_q  <= cmd_branch & bus.alu_bcond;
          err_q    <= cmd_illegal;
        end
        SHIFT: begin
          acc_q <= bus.alu_result;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            result_q <= bus.alu_result;
            bcond_q  <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_result = result_q;
  assign bus.rsp_bcond  = bcond_q;
  assign bus.rsp_err    = err_q;
  assign bus.alu_op     = alu_op;
  assign bus.alu_in_1   = alu_in_1;
  assign bus.alu_in_2   = alu_in_2;
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer: a driver pushes expected responses
// from a command-level reference model, a monitor pops and compares them.
module tb_alu_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  alu_sequencer_if #(.DATA_WIDTH(W)) bus();

  alu_sequencer #(.DATA_WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   cmd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         bcond;
    logic         err;
    logic [6:0]   op;
    logic         is_exec;
    int           lat;
    int           accept;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int busy_cycles = 0;
  bit mon_en = 1'b0;
  bit hold_rsp = 1'b0;

  // Reference ALU: single-bit shifts, signed compares for GE/LT.
  always_comb begin
    bus.alu_result = '0;
    bus.alu_bcond  = 1'b0;
    case (bus.alu_op[3:0])
      4'd0:  bus.alu_result = bus.alu_in_1 + bus.alu_in_2;
      4'd1:  bus.alu_result = bus.alu_in_1 - bus.alu_in_2;
      4'd2:  bus.alu_result = bus.alu_in_1;
      4'd3:  bus.alu_result = ~bus.alu_in_1;
      4'd4:  bus.alu_result = bus.alu_in_1 & bus.alu_in_2;
      4'd5:  bus.alu_result = bus.alu_in_1 | bus.alu_in_2;
      4'd6:  bus.alu_result = ~(bus.alu_in_1 & bus.alu_in_2);
      4'd7:  bus.alu_result = ~(bus.alu_in_1 | bus.alu_in_2);
      4'd8:  bus.alu_result = bus.alu_in_1 ^ bus.alu_in_2;
      4'd9:  bus.alu_result = ~(bus.alu_in_1 ^ bus.alu_in_2);
      4'd10: bus.alu_result = bus.alu_in_1 << 1;
      4'd11: bus.alu_result = bus.alu_in_1 >> 1;
      4'd12: bus.alu_result = bus.alu_in_1 << 1;
      4'd13: bus.alu_result = $signed(bus.alu_in_1) >>> 1;
      4'd14: bus.alu_result = -bus.alu_in_1;
      default: bus.alu_result = '0;
    endcase
    if (bus.alu_op[6]) begin
      case (bus.alu_op[5:4])
        2'd0: bus.alu_bcond = (bus.alu_in_1 == bus.alu_in_2);
        2'd1: bus.alu_bcond = (bus.alu_in_1 != bus.alu_in_2);
        2'd2: bus.alu_bcond = ($signed(bus.alu_in_1) >= $signed(bus.alu_in_2));
        default: bus.alu_bcond = ($signed(bus.alu_in_1) < $signed(bus.alu_in_2));
      endcase
    end
  end

  function automatic exp_t model(logic [3:0] cmd, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    int n;
    n = int'(b[4:0]);
    e.cmd = cmd; e.a = a; e.b = b;
    e.bcond = 1'b0; e.err = 1'b0; e.is_exec = 1'b1; e.lat = 2; e.accept = 0;
    e.result = '0; e.op = 7'h0F;
    case (cmd)
      4'd0:  begin e.result = a + b; e.op = 7'h00; end
      4'd1:  begin e.result = a - b; e.op = 7'h01; end
      4'd2:  begin e.result = a & b; e.op = 7'h04; end
      4'd3:  begin e.result = a | b; e.op = 7'h05; end
      4'd4:  begin e.result = a ^ b; e.op = 7'h08; end
      4'd5, 4'd6, 4'd7: begin
        if (cmd == 4'd5)      e.result = a << n;
        else if (cmd == 4'd6) e.result = a >> n;
        else                  e.result = $signed(a) >>> n;
        if (n == 0) e.op = 7'h02;
        else begin
          e.op = (cmd == 4'd5) ? 7'h0A : (cmd == 4'd6) ? 7'h0B : 7'h0D;
          e.is_exec = 1'b0;
          e.lat = n + 1;
        end
      end
      4'd8:  begin e.result = a - b; e.op = 7'h41; e.bcond = (a == b); end
      4'd9:  begin e.result = a - b; e.op = 7'h51; e.bcond = (a != b); end
      4'd10: begin e.result = a - b; e.op = 7'h61; e.bcond = ($signed(a) >= $signed(b)); end
      4'd11: begin e.result = a - b; e.op = 7'h71; e.bcond = ($signed(a) < $signed(b)); end
      4'd12: begin e.result = -a; e.op = 7'h0E; end
      default: begin e.result = '0; e.op = 7'h0F; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=event", name);
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops one expectation per response, checks ALU drive while busy
  // and response stability while the consumer stalls.
  initial begin
    exp_t cur;
    logic prev_valid, prev_ready;
    logic [W-1:0] held_result;
    logic held_bcond, held_err;
    prev_valid = 1'b0; prev_ready = 1'b0;
    held_result = '0; held_bcond = 1'b0; held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.rsp_valid) begin
          if (prev_valid && !prev_ready) begin
            check_output("hold_result", bus.rsp_result, held_result);
            check_output("hold_bcond", W'(bus.rsp_bcond), W'(held_bcond));
            check_output("hold_err", W'(bus.rsp_err), W'(held_err));
            check_output("hold_req_ready", W'(bus.req_ready), '0);
          end else if (sb.size() == 0) begin
            check_output("unexpected_rsp_valid", W'(bus.rsp_valid), '0);
          end else begin
            cur = sb.pop_front();
            check_output("rsp_result", bus.rsp_result, cur.result);
            check_output("rsp_bcond", W'(bus.rsp_bcond), W'(cur.bcond));
            check_output("rsp_err", W'(bus.rsp_err), W'(cur.err));
            check_output("latency", W'(cycle - cur.accept + 1), W'(cur.lat));
            check_output("busy_cycles", W'(busy_cycles), W'(cur.lat - 1));
            check_output("resp_alu_op", W'(bus.alu_op), W'(7'h0F));
            check_output("resp_alu_in", bus.alu_in_1 | bus.alu_in_2, '0);
            held_result = bus.rsp_result;
            held_bcond  = bus.rsp_bcond;
            held_err    = bus.rsp_err;
            busy_cycles = 0;
          end
        end else if (!bus.req_ready) begin
          if (sb.size() == 0) begin
            check_output("busy_without_request", W'(bus.req_ready), W'(1'b1));
          end else begin
            busy_cycles++;
            check_output("busy_alu_op", W'(bus.alu_op), W'(sb[0].op));
            if (sb[0].is_exec) begin
              check_output("exec_alu_in_1", bus.alu_in_1, sb[0].a);
              check_output("exec_alu_in_2", bus.alu_in_2, sb[0].b);
            end else begin
              check_output("shift_alu_in_2", bus.alu_in_2, '0);
            end
          end
        end
        prev_valid = bus.rsp_valid;
        prev_ready = bus.rsp_ready;
      end
    end
  end

  task automatic apply_stimulus(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int tries;
    e = model(cmd, a, b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_cmd = cmd;
    bus.req_a = a;
    bus.req_b = b;
    tries = 0;
    while (!bus.req_ready) begin
      if (tries >= 200) begin
        fail_now("accept_timeout");
        bus.req_valid = 1'b0;
        return;
      end
      tries++;
      @(negedge clk);
    end
    e.accept = cycle + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_cmd = 4'($urandom);
    bus.req_a = $urandom;
    bus.req_b = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.req_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_now("drain_timeout");
  endtask

  // Reset with a request offered throughout; it must be ignored.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_cmd = 4'd0;
    bus.req_a = 32'd1;
    bus.req_b = 32'd1;
    @(posedge clk);
    #1;
    sb.delete();
    busy_cycles = 0;
    @(negedge clk);
    check_output("reset_req_ready", W'(bus.req_ready), W'(1'b1));
    check_output("reset_rsp_valid", W'(bus.rsp_valid), '0);
    check_output("reset_rsp_result", bus.rsp_result, '0);
    check_output("reset_rsp_bcond", W'(bus.rsp_bcond), '0);
    check_output("reset_rsp_err", W'(bus.rsp_err), '0);
    check_output("reset_alu_op", W'(bus.alu_op), W'(7'h0F));
    check_output("reset_alu_in_1", bus.alu_in_1, '0);
    check_output("reset_alu_in_2", bus.alu_in_2, '0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_output("post_reset_idle", W'(bus.req_ready), W'(1'b1));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    int n;
    bus.req_valid = 1'b0;
    bus.req_cmd = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    do_reset();
    mon_en = 1'b1;

    apply_stimulus(4'd0, 32'h7FFF_FFFF, 32'd1);
    apply_stimulus(4'd11, 32'hFFFF_FFFF, 32'd1);
    apply_stimulus(4'd8, 32'd5, 32'd5);
    apply_stimulus(4'd9, 32'd5, 32'd5);
    apply_stimulus(4'd7, 32'h8000_0000, 32'd31);
    apply_stimulus(4'd5, 32'd1, 32'd0);
    wait_idle();

    hold_rsp = 1'b1;
    apply_stimulus(4'd14, $urandom, $urandom);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("stall_rsp_timeout");
    repeat (6) @(negedge clk);
    hold_rsp = 1'b0;
    wait_idle();

    apply_stimulus(4'd5, $urandom, 32'd20);
    repeat (6) @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    apply_stimulus(4'd0, 32'd2, 32'd3);
    wait_idle();

    for (int i = 0; i < 150; i++) begin
      ra = pick_operand();
      rb = ($urandom_range(0, 5) == 0) ? ra : pick_operand();
      apply_stimulus(4'($urandom_range(0, 15)), ra, rb);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
